// File: rtl/fi_pkg.sv
// Shared types and constants for the fault-injection sequencer.
// Mode/state encodings, LFSR polynomial and default seed.
package fi_pkg;

    localparam int unsigned FI_LFSR_W    = 16;
    localparam logic [15:0] FI_LFSR_TAPS = 16'hB400;
    localparam logic [15:0] FI_LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        FI_SINGLE    = 2'd0,
        FI_PERIODIC  = 2'd1,
        FI_PER_RAND  = 2'd2,
        FI_RAND_RAND = 2'd3
    } fi_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_INJECT = 2'd2,
        ST_DONE   = 2'd3
    } fi_state_e;

    // One right-shifting Galois step.
    function automatic logic [15:0] fi_lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ FI_LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/fault_inject_ctrl_if.sv
// Configuration and injection-port bundle of the fault-injection sequencer.
// master = configuring agent, slave = sequencer.
interface fault_inject_ctrl_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 16
);
    logic              cfg_start;
    logic              cfg_stop;
    logic [1:0]        cfg_mode;
    logic [DATA_W-1:0] cfg_pattern;
    logic [CNT_W-1:0]  cfg_interval;
    logic [3:0]        cfg_width;
    logic [CNT_W-1:0]  cfg_num;
    logic              inj_en;
    logic [DATA_W-1:0] inj_data;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  inj_count;

    modport master (
        output cfg_start, cfg_stop, cfg_mode, cfg_pattern, cfg_interval, cfg_width, cfg_num,
        input  inj_en, inj_data, busy, done, inj_count
    );

    modport slave (
        input  cfg_start, cfg_stop, cfg_mode, cfg_pattern, cfg_interval, cfg_width, cfg_num,
        output inj_en, inj_data, busy, done, inj_count
    );
endinterface

// File: rtl/fi_lfsr.sv
// 16-bit Galois LFSR (taps 16'hB400); advances only while en is high.
module fi_lfsr
    import fi_pkg::*;
#(
    parameter logic [15:0] SEED = FI_LFSR_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    output logic [15:0] state_o
);
    logic [15:0] lfsr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    lfsr_q <= SEED;
        else if (en_i) lfsr_q <= fi_lfsr_next(lfsr_q);
    end

    assign state_o = lfsr_q;
endmodule

// File: rtl/fault_inject_ctrl.sv
// Fault-injection sequencer: single, periodic and random upsets on the
// tmr_wrapper injection port, with run counting and completion pulse.
module fault_inject_ctrl
    import fi_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned CNT_W     = 16,
    parameter logic [15:0] LFSR_SEED = FI_LFSR_SEED
) (
    input  logic               clk,
    input  logic               rst_n,
    fault_inject_ctrl_if.slave bus
);
    fi_state_e         state_q, state_d;
    fi_mode_e          mode_q, mode_d;
    logic [DATA_W-1:0] pattern_q, pattern_d;
    logic [CNT_W-1:0]  interval_q, interval_d;
    logic [3:0]        width_q, width_d;
    logic [CNT_W-1:0]  num_q, num_d;
    logic [CNT_W-1:0]  wait_q, wait_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic              inj_en_q, inj_en_d;
    logic [DATA_W-1:0] inj_data_q, inj_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [15:0]       lfsr;
    logic [DATA_W-1:0] mask_raw_c, mask_c;

    fi_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (busy_q),
        .state_o (lfsr)
    );

    // Effective wait length; mode 3 masks the interval with the LFSR.
    function automatic logic [CNT_W-1:0] wait_len(input fi_mode_e mode,
                                                  input logic [CNT_W-1:0] ival,
                                                  input logic [15:0] rnd);
        logic [CNT_W-1:0] raw;
        raw = (mode == FI_RAND_RAND) ? (rnd[CNT_W-1:0] & ival) : ival;
        return (raw == '0) ? CNT_W'(1) : raw;
    endfunction

    always_comb begin
        mask_raw_c = (mode_q == FI_SINGLE || mode_q == FI_PERIODIC) ? pattern_q
                                                                    : lfsr[DATA_W-1:0];
        mask_c     = (mask_raw_c == '0) ? DATA_W'(1) : mask_raw_c;
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        pattern_d  = pattern_q;
        interval_d = interval_q;
        width_d    = width_q;
        num_d      = num_q;
        wait_d     = wait_q;
        wcnt_d     = wcnt_q;
        inj_en_d   = inj_en_q;
        inj_data_d = inj_data_q;
        done_d     = 1'b0;
        count_d    = count_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.cfg_start && !bus.cfg_stop) begin
                    state_d    = ST_WAIT;
                    mode_d     = fi_mode_e'(bus.cfg_mode);
                    pattern_d  = bus.cfg_pattern;
                    interval_d = bus.cfg_interval;
                    width_d    = (bus.cfg_width == 4'd0) ? 4'd1 : bus.cfg_width;
                    num_d      = (fi_mode_e'(bus.cfg_mode) == FI_SINGLE) ? CNT_W'(1)
                                                                         : bus.cfg_num;
                    count_d    = '0;
                    wait_d     = wait_len(fi_mode_e'(bus.cfg_mode), bus.cfg_interval, lfsr);
                end
            end
            ST_WAIT: begin
                if (wait_q <= CNT_W'(1)) begin
                    state_d    = ST_INJECT;
                    inj_en_d   = 1'b1;
                    inj_data_d = mask_c;
                    wcnt_d     = width_q;
                    count_d    = (count_q == '1) ? count_q : count_q + CNT_W'(1);
                end else begin
                    wait_d = wait_q - CNT_W'(1);
                end
            end
            ST_INJECT: begin
                if (wcnt_q <= 4'd1) begin
                    inj_en_d   = 1'b0;
                    inj_data_d = '0;
                    if (num_q != '0 && count_q == num_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        wait_d  = wait_len(mode_q, interval_q, lfsr);
                    end
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides everything, including an expiry on the same edge.
        if (bus.cfg_stop && state_q != ST_IDLE) begin
            state_d    = ST_IDLE;
            inj_en_d   = 1'b0;
            inj_data_d = '0;
            done_d     = 1'b0;
            count_d    = count_q;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mode_q     <= FI_SINGLE;
            pattern_q  <= '0;
            interval_q <= '0;
            width_q    <= 4'd1;
            num_q      <= '0;
            wait_q     <= '0;
            wcnt_q     <= '0;
            inj_en_q   <= 1'b0;
            inj_data_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            pattern_q  <= pattern_d;
            interval_q <= interval_d;
            width_q    <= width_d;
            num_q      <= num_d;
            wait_q     <= wait_d;
            wcnt_q     <= wcnt_d;
            inj_en_q   <= inj_en_d;
            inj_data_q <= inj_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            count_q    <= count_d;
        end
    end

    assign bus.inj_en    = inj_en_q;
    assign bus.inj_data  = inj_data_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.inj_count = count_q;
endmodule
